// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter.
// The TAG_* states exist only when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  // High nibble of the tag byte announcing which requester owns the next byte
  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  // Handshake timeout counter width; covers TIMEOUT values up to 65535
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_IDLE,
    SEND,
    RELEASE
`ifdef UART_ARB_TAG_EN
    ,
    TAG_WAIT,
    TAG_SEND,
    TAG_RELEASE
`endif
  } arbState_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick among NUM_REQ requesters.
// The pointer holds the highest-priority index: one past the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       ipClk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         ipReq,
  input  logic                       ipAdvance,
  input  logic [$clog2(NUM_REQ)-1:0] ipLastIdx,
  output logic [$clog2(NUM_REQ)-1:0] opPick
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] src;

  // Masked priority pick: lowest valid at or above ptr, else lowest valid overall
  always_comb begin
    masked = ipReq & ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    src    = (|masked) ? masked : ipReq;
    opPick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (src[i]) opPick = IDX_W'(i);
    end
  end

  // Advance the pointer past the requester that actually got a byte accepted
  always_ff @(posedge ipClk) begin
    if (reset) begin
      ptr <= '0;
    end else if (ipAdvance) begin
      ptr <= (ipLastIdx == IDX_W'(NUM_REQ - 1)) ? '0 : ipLastIdx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbitration of byte requesters onto one UART
// transmitter with a send/busy handshake and timeout.
// Optional: define UART_ARB_TAG_EN to precede each data byte with a tag
// byte {4'hA, requester index}.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 ipClk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   ipReqValid,
  input  logic [8*NUM_REQ-1:0] ipReqData,
  output logic [NUM_REQ-1:0]   opReqReady,
  output logic [7:0]           opTxData,
  output logic                 opTxSend,
  input  logic                 ipTxBusy,
  output logic                 opError
);

  import uart_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  arbState_t        state, nextState;
  logic [IDX_W-1:0] selIdx;
  logic [IDX_W-1:0] pickIdx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       reqByte;
  logic             grantFire;
  logic             inSend;
  logic             timeoutHit;
  logic             timeoutFire;
  logic             errReg;
`ifdef UART_ARB_TAG_EN
  logic [7:0]       dataHold;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uRr (
    .ipClk     (ipClk),
    .reset     (reset),
    .ipReq     (ipReqValid),
    .ipAdvance (grantFire),
    .ipLastIdx (selIdx),
    .opPick    (pickIdx)
  );

  // Handshake qualifiers; the grant only fires while the selected requester is still valid
  always_comb begin
    reqByte     = ipReqData[8*selIdx +: 8];
    grantFire   = (state == GRANT) && ipReqValid[selIdx];
`ifdef UART_ARB_TAG_EN
    inSend      = (state == SEND) || (state == TAG_SEND);
`else
    inSend      = (state == SEND);
`endif
    timeoutHit  = (cnt == CNT_W'(TIMEOUT - 1));
    timeoutFire = inSend && !ipTxBusy && timeoutHit;
  end

  // Next-state and strobe outputs
  always_comb begin
    nextState  = state;
    opReqReady = '0;
    opTxSend   = inSend;
    if (grantFire) opReqReady = NUM_REQ'(1) << selIdx;
    case (state)
      IDLE:      if (|ipReqValid) nextState = GRANT;
`ifdef UART_ARB_TAG_EN
      GRANT:     nextState = grantFire ? TAG_WAIT : IDLE;
      TAG_WAIT:  if (!ipTxBusy) nextState = TAG_SEND;
      TAG_SEND:  if (ipTxBusy) nextState = TAG_RELEASE;
                 else if (timeoutHit) nextState = IDLE;
      TAG_RELEASE: nextState = WAIT_IDLE;
`else
      GRANT:     nextState = grantFire ? WAIT_IDLE : IDLE;
`endif
      WAIT_IDLE: if (!ipTxBusy) nextState = SEND;
      SEND:      if (ipTxBusy) nextState = RELEASE;
                 else if (timeoutHit) nextState = IDLE;
      RELEASE:   nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // State, selection, timeout counter and byte registers
  always_ff @(posedge ipClk) begin
    if (reset) begin
      state    <= IDLE;
      selIdx   <= '0;
      cnt      <= '0;
      opTxData <= 8'h00;
      errReg   <= 1'b0;
`ifdef UART_ARB_TAG_EN
      dataHold <= 8'h00;
`endif
    end else begin
      state  <= nextState;
      errReg <= timeoutFire;
      if (state == IDLE) selIdx <= pickIdx;
      // Counts SEND cycles without busy; cleared on every exit from SEND
      if (inSend && !ipTxBusy && !timeoutHit) cnt <= cnt + CNT_W'(1);
      else cnt <= '0;
`ifdef UART_ARB_TAG_EN
      if (grantFire) begin
        opTxData <= {TAG_NIBBLE, 4'(selIdx)};
        dataHold <= reqByte;
      end
      if (state == TAG_RELEASE) opTxData <= dataHold;
`else
      if (grantFire) opTxData <= reqByte;
`endif
    end
  end

  assign opError = errReg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed + randomized checks of uart_tx_arbiter against a
// queue-based reference model and a behavioural UART busy model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 1023;
`ifdef UART_ARB_TAG_EN
  localparam int BPG = 2;
`else
  localparam int BPG = 1;
`endif

  logic           ipClk = 1'b0;
  logic           reset;
  logic [N-1:0]   ipReqValid;
  logic [8*N-1:0] ipReqData;
  logic [N-1:0]   opReqReady;
  logic [7:0]     opTxData;
  logic           opTxSend;
  logic           ipTxBusy;
  logic           opError;

  always #5 ipClk = ~ipClk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .ipClk      (ipClk),
    .reset      (reset),
    .ipReqValid (ipReqValid),
    .ipReqData  (ipReqData),
    .opReqReady (opReqReady),
    .opTxData   (opTxData),
    .opTxSend   (opTxSend),
    .ipTxBusy   (ipTxBusy),
    .opError    (opError)
  );

  int nVec = 0;
  int nErr = 0;

  // Requester sources: per-requester byte FIFOs
  logic [7:0] srcMem [N][8];
  int         srcHead [N];
  int         srcTail [N];
  logic [N-1:0] pendRdy;

  // Reference model state and observation logs
  logic [7:0] expQ[$];
  logic [7:0] txLog[$];
  int         mPtr;

  // UART model knobs
  bit uartAuto;
  int uDelay, uLen, sendCyc, busyCnt;

  int sendPeriods, sendHigh, errCount, holdBad, oneHotBad;
  logic [7:0]   curByte;
  bit           prevSnd;
  logic [N-1:0] lastRdy;
  logic         lastSnd, lastErr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic updSrc();
    for (int i = 0; i < N; i++) begin
      ipReqValid[i] = (srcHead[i] != srcTail[i]);
      ipReqData[8*i +: 8] = ipReqValid[i] ? srcMem[i][srcHead[i]] : 8'h00;
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    srcMem[i][srcTail[i]] = b;
    srcTail[i]++;
  endtask

  task automatic clrSrc();
    for (int i = 0; i < N; i++) begin
      srcHead[i] = 0;
      srcTail[i] = 0;
    end
    pendRdy = '0;
  endtask

  // One clock: observe at the falling edge, run the models, then drive inputs
  task automatic tick();
    int  e;
    int  j;
    bit  wasRst;
    @(negedge ipClk);
    wasRst = reset;
    for (int i = 0; i < N; i++)
      if (pendRdy[i] && srcHead[i] < srcTail[i]) srcHead[i]++;
    lastRdy = opReqReady;
    lastSnd = opTxSend;
    lastErr = opError;
    if ($countones(lastRdy) > 1) oneHotBad++;
    if (lastRdy != '0 && !wasRst) begin
      e = -1;
      for (int k = 0; k < N; k++) begin
        j = (mPtr + k) % N;
        if (e < 0 && ipReqValid[j]) e = j;
      end
      chk("rr_pick", 32'(lastRdy), (e < 0) ? 32'd0 : (32'd1 << e));
      if (e >= 0) begin
`ifdef UART_ARB_TAG_EN
        expQ.push_back({4'hA, 4'(e)});
`endif
        expQ.push_back(srcMem[e][srcHead[e]]);
        mPtr = (e + 1) % N;
      end
    end
    pendRdy = lastRdy;
    if (wasRst) prevSnd = 1'b0;
    if (lastErr) errCount++;
    if (lastSnd) sendHigh++;
    if (lastSnd && !prevSnd) begin
      sendPeriods++;
      curByte = opTxData;
    end
    if ((lastSnd || prevSnd) && opTxData !== curByte) holdBad++;
    prevSnd = lastSnd;
    if (uartAuto) begin
      if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) ipTxBusy = 1'b0;
      end else if (lastSnd) begin
        sendCyc++;
        if (sendCyc >= uDelay) begin
          ipTxBusy = 1'b1;
          busyCnt  = uLen;
          sendCyc  = 0;
        end
      end else begin
        sendCyc = 0;
      end
    end
    if (lastSnd && ipTxBusy) txLog.push_back(opTxData);
    updSrc();
  endtask

  task automatic runUntil(input int n, input int budget, input string tag);
    int c = 0;
    while (txLog.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_budget"}, (txLog.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic compareLog(input string tag);
    chk({tag, "_count"}, txLog.size(), expQ.size());
    for (int k = 0; k < txLog.size() && k < expQ.size(); k++)
      chk({tag, "_byte"}, 32'(txLog[k]), 32'(expQ[k]));
    txLog.delete();
    expQ.delete();
  endtask

  initial begin
    int total;
    int c;
    reset = 1'b1;
    ipReqValid = '0;
    ipReqData = '0;
    ipTxBusy = 1'b0;
    uartAuto = 1'b1;
    uDelay = 3; uLen = 4; sendCyc = 0; busyCnt = 0;
    sendPeriods = 0; sendHigh = 0; errCount = 0; holdBad = 0; oneHotBad = 0;
    curByte = 8'h00; prevSnd = 1'b0; mPtr = 0;
    clrSrc();

    // Reset values
    repeat (3) tick();
    chk("rst_ready", 32'(opReqReady), 32'd0);
    chk("rst_send",  32'(opTxSend),   32'd0);
    chk("rst_data",  32'(opTxData),   32'h00);
    chk("rst_error", 32'(opError),    32'd0);
    reset = 1'b0;
    tick();

    // All four requesters valid: strict rotation 10,11,12,13 twice
    clrSrc();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 8'h10 + 8'(i));
    runUntil(8 * BPG, 400, "rr_all");
    repeat (10) tick();
`ifndef UART_ARB_TAG_EN
    for (int k = 0; k < 8 && k < txLog.size(); k++)
      chk("rr_order", 32'(txLog[k]), 32'h10 + 32'(k % 4));
`endif
    compareLog("rr_all");

    // Single requester 2: two-cycle grant latency, one send period, data held
    clrSrc();
    sendPeriods = 0;
    push(2, 8'h5A);
    tick();
    tick();
    chk("lat_ready", 32'(lastRdy), 32'b0100);
    tick();
    chk("ready_one_cycle", 32'(lastRdy), 32'd0);
    runUntil(BPG, 100, "req2");
    repeat (10) tick();
    chk("req2_sends", sendPeriods, BPG);
    chk("req2_hold", holdBad, 0);
    if (txLog.size() == BPG) chk("req2_byte", 32'(txLog[BPG-1]), 32'h5A);
    compareLog("req2");

    // Busy already high at grant: send waits for busy to fall
    clrSrc();
    uartAuto = 1'b0;
    ipTxBusy = 1'b1;
    sendPeriods = 0;
    push(1, 8'h77);
    repeat (12) tick();
    chk("busy_no_send", sendPeriods, 0);
`ifdef UART_ARB_TAG_EN
    chk("busy_data", 32'(opTxData), 32'hA1);
`else
    chk("busy_data", 32'(opTxData), 32'h77);
`endif
    ipTxBusy = 1'b0;
    uartAuto = 1'b1;
    sendCyc = 0; busyCnt = 0;
    tick();
    chk("send_after_busy", 32'(lastSnd), 32'd1);
    runUntil(BPG, 100, "busy");
    repeat (10) tick();
    compareLog("busy");

    // Busy never rises: timeout after TMO send cycles, byte dropped
    clrSrc();
    uartAuto = 1'b0;
    ipTxBusy = 1'b0;
    errCount = 0;
    sendHigh = 0;
    push(0, 8'hC3);
    c = 0;
    lastErr = 1'b0;
    while (!lastErr && c < TMO + 200) begin
      tick();
      c++;
    end
    chk("to_err",        32'(lastErr), 32'd1);
    chk("to_send_low",   32'(lastSnd), 32'd0);
    chk("to_send_cycles", sendHigh, TMO);
    repeat (5) tick();
    chk("to_err_once", errCount, 1);
    repeat (BPG) if (expQ.size() > 0) void'(expQ.pop_back());
    uartAuto = 1'b1;
    sendCyc = 0; busyCnt = 0;
    push(1, 8'h21);
    tick();
    tick();
    chk("to_regrant", 32'(lastRdy), 32'b0010);
    runUntil(BPG, 100, "to");
    repeat (10) tick();
    compareLog("to");

    // Reset mid-send: send drops, no error, pointer back to requester 0
    clrSrc();
    uartAuto = 1'b0;
    ipTxBusy = 1'b0;
    errCount = 0;
    push(3, 8'h99);
    c = 0;
    lastSnd = 1'b0;
    while (!lastSnd && c < 40) begin
      tick();
      c++;
    end
    chk("rst_mid_sending", 32'(lastSnd), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid_send_drop", 32'(lastSnd), 32'd0);
    chk("rst_mid_data",      32'(opTxData), 32'h00);
    reset = 1'b0;
    mPtr = 0;
    repeat (BPG) if (expQ.size() > 0) void'(expQ.pop_back());
    repeat (TMO + 80) tick();
    chk("rst_no_error", errCount, 0);
    uartAuto = 1'b1;
    sendCyc = 0; busyCnt = 0;
    clrSrc();
    for (int i = 0; i < N; i++) push(i, 8'($urandom));
    tick();
    tick();
    chk("rst_first_grant", 32'(lastRdy), 32'b0001);
    runUntil(N * BPG, 400, "rst");
    repeat (10) tick();
    compareLog("rst");

`ifdef UART_ARB_TAG_EN
    // Tag byte precedes the data byte
    clrSrc();
    push(1, 8'h33);
    runUntil(2, 100, "tag");
    repeat (10) tick();
    if (txLog.size() >= 2) begin
      chk("tag_first",  32'(txLog[0]), 32'hA1);
      chk("tag_second", 32'(txLog[1]), 32'h33);
    end
    compareLog("tag");
`endif

    // Randomized rounds: random backlogs, data and UART timing
    for (int r = 0; r < 6; r++) begin
      clrSrc();
      total = 0;
      uDelay = $urandom_range(1, 4);
      uLen   = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) begin
        c = $urandom_range(0, 3);
        for (int k = 0; k < c; k++) push(i, 8'($urandom));
        total += c;
      end
      runUntil(total * BPG, 40 * total * BPG + 20, "rand");
      repeat (12) tick();
      compareLog("rand");
    end

    chk("ready_onehot", oneHotBad, 0);
    chk("data_hold_all", holdBad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum cycles to wait for ipTxBusy high after asserting opTxSend.
REQ-003 SHALL have port ipClk  input  1  clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset; clock ipClk.
REQ-005 SHALL have port ipReqValid  input  NUM_REQ  per-requester byte available.
REQ-006 SHALL have port ipReqData  input  8*NUM_REQ  requester i byte at bits [8i+7:8i].
REQ-007 SHALL have port opReqReady  output  NUM_REQ  one-cycle, one-hot byte-accepted strobe.
REQ-008 SHALL have port opTxData  output  8  byte to the UART transmitter.
REQ-009 SHALL have port opTxSend  output  1  UART send request.
REQ-010 SHALL have port ipTxBusy  input  1  UART transmitter busy.
REQ-011 SHALL have port opError  output  1  one-cycle pulse on handshake timeout.

Function
REQ-012 SHALL implement states IDLE, GRANT, WAIT_IDLE, SEND, RELEASE (plus TAG_* states when REQ-024 applies).
REQ-013 IDLE: if any ipReqValid bit is high, SHALL select a requester round-robin, starting one past the last granted index and wrapping at NUM_REQ-1; the pointer after reset SHALL be 0; otherwise stay in IDLE.
REQ-014 GRANT: SHALL pulse opReqReady[i] for exactly one cycle, capture ipReqData byte i into opTxData, and go to WAIT_IDLE; a requester is only granted while its ipReqValid is high.
REQ-015 WAIT_IDLE: SHALL hold opTxData stable and opTxSend low until ipTxBusy is low, then go to SEND.
REQ-016 SEND: SHALL drive opTxSend high and count cycles; on ipTxBusy high go to RELEASE; if the count reaches TIMEOUT, SHALL drive opTxSend low, pulse opError, drop the byte and return to IDLE.
REQ-017 RELEASE: SHALL drive opTxSend low for at least one cycle, then return to IDLE; opTxData SHALL stay stable until it leaves RELEASE.
REQ-018 Latency: opReqReady SHALL assert 2 cycles after ipReqValid rises in IDLE (select in IDLE, strobe in GRANT).
REQ-019 opTxSend SHALL never be high while the FSM is in IDLE, GRANT, WAIT_IDLE or RELEASE.
REQ-020 At most one opReqReady bit SHALL be high per cycle; it SHALL be low in every state except GRANT.
REQ-021 A requester that keeps ipReqValid high SHALL receive one byte per grant, and SHALL not be granted again while another requester is valid.

Reset
REQ-022 On reset, outputs SHALL be: opReqReady=0, opTxSend=0, opTxData=8'h00, opError=0; state SHALL be IDLE; round-robin pointer SHALL be 0; timeout counter SHALL be 0.
REQ-023 Reset during SEND or RELEASE SHALL drop opTxSend on the next edge and discard the captured byte without an opError pulse.

Configuration
REQ-024 With UART_ARB_TAG_EN defined, each grant SHALL first send a tag byte {4'hA, 4'(i)} through the full WAIT_IDLE/SEND/RELEASE handshake, then the data byte; a tag timeout SHALL abort both bytes.
REQ-025 Without UART_ARB_TAG_EN, only the data byte SHALL be sent, and no tag states or logic SHALL exist.

Structure
REQ-026 The state enum, the tag nibble 4'hA and the counter width SHALL reside in package uart_arb_pkg.
REQ-027 Round-robin selection (pointer register plus masked priority pick) SHALL be a sub-module rr_arbiter, parameterised by NUM_REQ.

Verification
REQ-028 ipReqValid=4'b1111 with data 8'h10/11/12/13 and a UART model (busy rises 3 cycles after send) -> bytes 10,11,12,13 in order; sequence repeats.
REQ-029 Only requester 2 valid, with data 8'h5A -> opReqReady=4'b0100 after 2 cycles; one opTxSend high period; opTxData=8'h5A held until RELEASE ends.
REQ-030 ipTxBusy held low forever after send -> opError pulses once after 1023 cycles in SEND; opTxSend low; FSM in IDLE.
REQ-031 ipTxBusy high at grant -> opTxSend stays low until busy falls, then asserts.
REQ-032 reset asserted while opTxSend=1 -> opTxSend=0 next cycle; opError never pulses; next grant goes to requester 0 first.
REQ-033 UART_ARB_TAG_EN defined, requester 1 sends 8'h33 -> transmitted sequence 8'hA1 then 8'h33.
